// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller that stores words in an external single-port
// synchronous RAM and presents the head word from a local output register.
// Capacity is DEPTH words in RAM plus one in the output register.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   push request
//   in_ready   push accepted when in_valid & in_ready at posedge
//   in_data    push word
//   out_valid  out_data holds the FIFO head
//   out_ready  pop when out_valid & out_ready at posedge
//   out_data   head word
//   count      total words held (RAM + output register)
//   full       RAM holds DEPTH words
//   empty      count == 0
//   ram_cs     RAM chip select
//   ram_we     RAM write enable
//   ram_oe     RAM output enable
//   ram_addr   RAM address
//   ram_data   RAM bidirectional data bus (driven only on write cycles)
//
// RAM read protocol: address is presented in one cycle (StIdle issuing the
// read) and the RAM drives ram_data during the following cycle (StRdData),
// where the word is captured into the output register.
module ram_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  typedef enum logic [0:0] {
    StIdle,
    StRdData
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic need_read;
  logic pop;
  logic ram_wr_en;

  // Status flags come straight from registered state.
  assign full      = (ram_count_q == (ADDR_WIDTH + 1)'(DEPTH));
  assign count     = ram_count_q + {{ADDR_WIDTH{1'b0}}, out_valid_q};
  assign empty     = (count == '0);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Refill the output register whenever it is empty and RAM holds data.
  // Uses the registered out_valid, so a pop never triggers a read in the same
  // cycle; the read follows one cycle later.
  assign need_read = (state_q == StIdle) && !out_valid_q && (ram_count_q != '0);
  assign pop       = out_valid_q && out_ready;

  // Bus is released except while a write is in progress.
  assign ram_data = ram_wr_en ? in_data : {DATA_WIDTH{1'bz}};

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    in_ready  = 1'b0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_oe    = 1'b1;
    ram_addr  = rd_ptr_q;
    ram_wr_en = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (need_read) begin
          ram_cs   = 1'b1;
          ram_we   = 1'b0;
          ram_oe   = 1'b1;
          ram_addr = rd_ptr_q;
          state_d  = StRdData;
        end else begin
          in_ready = !full;
          if (in_valid && !full) begin
            ram_cs      = 1'b1;
            ram_we      = 1'b1;
            ram_oe      = 1'b0;
            ram_addr    = wr_ptr_q;
            ram_wr_en   = 1'b1;
            wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(1);
            ram_count_d = ram_count_q + (ADDR_WIDTH + 1)'(1);
          end
        end
        if (pop) begin
          out_valid_d = 1'b0;
        end
      end

      StRdData: begin
        // RAM is driving the word addressed last cycle; keep the read
        // controls stable and capture at the edge.
        ram_cs      = 1'b1;
        ram_we      = 1'b0;
        ram_oe      = 1'b1;
        ram_addr    = rd_ptr_q;
        out_data_d  = ram_data;
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
        ram_count_d = ram_count_q - (ADDR_WIDTH + 1)'(1);
        state_d     = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Reset overrides every RAM-facing output so nothing is accessed while
    // the register state is being cleared.
    if (rst) begin
      in_ready  = 1'b0;
      ram_cs    = 1'b0;
      ram_we    = 1'b0;
      ram_oe    = 1'b1;
      ram_wr_en = 1'b0;
    end
  end

  // A reset that lands in StRdData simply discards the in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl: external RAM model plus a queue-based FIFO
// reference model; directed reset/latency/fill/drain steps, a random wrap
// phase and a reset during a RAM read.
module tb_ram_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          ram_cs;
  logic          ram_we;
  logic          ram_oe;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;

  ram_fifo_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_oe   (ram_oe),
    .ram_addr (ram_addr),
    .ram_data (ram_data)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM: data for a read addressed in one cycle is
  // driven during the next cycle while the read controls are still asserted.
  logic [DW-1:0] mem [DEPTH];
  logic          rd_pend   = 1'b0;
  logic [AW-1:0] rd_addr_q = '0;
  int            ram_writes = 0;

  always @(posedge clk) begin
    if (ram_cs && ram_we) begin
      mem[ram_addr] <= ram_data;
      ram_writes    <= ram_writes + 1;
    end
    rd_pend   <= ram_cs && !ram_we && ram_oe;
    rd_addr_q <= ram_addr;
  end

  assign ram_data = (rd_pend && ram_cs && !ram_we && ram_oe) ? mem[rd_addr_q] : {DW{1'bz}};

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] q[$];
  int            streak   = 0;
  int            cyc_no   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle against the reference model: drive, compare, advance.
  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy,
                     output logic pushed, output logic popped);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    pushed = in_valid && in_ready;
    popped = out_valid && out_ready;
    check("count", 32'(count), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'((q.size() - (out_valid ? 1 : 0)) == DEPTH));
    if (in_valid && full) check("stall_no_write", 32'(ram_we), 32'd0);
    if (popped) check("pop_data", 32'(out_data), 32'(q[0]));
    // Head must become visible within 3 cycles of data reaching the FIFO.
    if (q.size() != 0 && !out_valid) streak++;
    else streak = 0;
    check("refill_latency", 32'(streak <= 2), 32'd1);
    @(posedge clk);
    #1;
    if (popped) void'(q.pop_front());
    if (pushed) q.push_back(d);
    cyc_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p, po;
    int   accepted, n_pop, last, pushes, both, w0;

    // Reset held for two edges.
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_ram_cs", 32'(ram_cs), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_oe", 32'(ram_oe), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_empty", 32'(empty), 32'd1);
    check("post_rst_full", 32'(full), 32'd0);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_ram_cs", 32'(ram_cs), 32'd0);

    // Single word: write in N, read issue in N+1, visible in N+3.
    in_valid  = 1'b1;
    in_data   = 16'hA5A5;
    out_ready = 1'b0;
    #1;
    check("single_wr_cs", 32'(ram_cs), 32'd1);
    check("single_wr_we", 32'(ram_we), 32'd1);
    check("single_wr_oe", 32'(ram_oe), 32'd0);
    check("single_wr_addr", 32'(ram_addr), 32'd0);
    check("single_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    check("single_mem0", 32'(mem[0]), 32'hA5A5);
    check("single_rd_cs", 32'(ram_cs), 32'd1);
    check("single_rd_we", 32'(ram_we), 32'd0);
    check("single_rd_oe", 32'(ram_oe), 32'd1);
    check("single_rd_addr", 32'(ram_addr), 32'd0);
    check("single_rd_in_ready", 32'(in_ready), 32'd0);
    check("single_count_n1", 32'(count), 32'd1);
    @(posedge clk);
    #1;
    check("single_count_n2", 32'(count), 32'd1);
    check("single_valid_n2", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("single_valid_n3", 32'(out_valid), 32'd1);
    check("single_data_n3", 32'(out_data), 32'hA5A5);
    check("single_count_n3", 32'(count), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("single_pop_valid", 32'(out_valid), 32'd0);
    check("single_pop_empty", 32'(empty), 32'd1);

    // Fill to capacity DEPTH+1.
    accepted = 0;
    for (int i = 0; i < 200 && accepted < 17; i++) begin
      cyc(1'b1, DW'(accepted + 1), 1'b0, p, po);
      if (p) accepted++;
    end
    check("fill_accepted", 32'(accepted), 32'd17);
    #1;
    check("fill_count", 32'(count), 32'd17);
    check("fill_full", 32'(full), 32'd1);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    w0 = ram_writes;
    cyc(1'b1, 16'h0012, 1'b0, p, po);
    check("fill_18th_accepted", 32'(p), 32'd0);
    check("fill_18th_no_write", 32'(ram_writes), 32'(w0));
    check("fill_18th_count", 32'(count), 32'd17);

    // Drain: in order, one word every 3 cycles.
    n_pop = 0;
    last  = -1;
    for (int i = 0; i < 200 && q.size() > 0; i++) begin
      cyc(1'b0, '0, 1'b1, p, po);
      if (po) begin
        if (last >= 0) check("drain_gap", 32'(cyc_no - 1 - last), 32'd3);
        last = cyc_no - 1;
        n_pop++;
      end
    end
    check("drain_pops", 32'(n_pop), 32'd17);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_count", 32'(count), 32'd0);

    // Random traffic across pointer wrap, occupancy kept around 5..12.
    pushes = 0;
    both   = 0;
    for (int i = 0; i < 3000 && pushes < 40; i++) begin
      logic iv, ordy;
      if (q.size() < 5) begin
        iv   = 1'b1;
        ordy = 1'b0;
      end else if (q.size() >= 12) begin
        iv   = 1'b0;
        ordy = 1'b1;
      end else begin
        iv   = 1'($urandom_range(0, 1));
        ordy = 1'($urandom_range(0, 1));
      end
      cyc(iv, DW'($urandom), ordy, p, po);
      if (p) pushes++;
      if (p && po) both++;
    end
    check("wrap_pushes", 32'(pushes), 32'd40);
    check("wrap_saw_push_pop", 32'(both > 0), 32'd1);
    for (int i = 0; i < 200 && q.size() > 0; i++) begin
      cyc(1'b0, '0, 1'b1, p, po);
    end
    check("wrap_drained", 32'(q.size()), 32'd0);
    check("wrap_empty", 32'(empty), 32'd1);

    // Reset during the read-data cycle aborts the capture.
    in_valid  = 1'b1;
    in_data   = 16'hBEEF;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    check("midrd_issue_cs", 32'(ram_cs), 32'd1);
    check("midrd_issue_we", 32'(ram_we), 32'd0);
    @(posedge clk);
    #1;
    check("midrd_data_cs", 32'(ram_cs), 32'd1);
    rst = 1'b1;
    #1;
    check("midrd_rst_cs", 32'(ram_cs), 32'd0);
    check("midrd_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrd_out_valid", 32'(out_valid), 32'd0);
    check("midrd_count", 32'(count), 32'd0);
    check("midrd_ram_cs", 32'(ram_cs), 32'd0);
    check("midrd_out_data", 32'(out_data), 32'd0);
    q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 The block SHALL have one clock, `clk`, and a synchronous, active-high reset, `rst`.
REQ-002 Parameters SHALL be:
- ADDR_WIDTH, default 4, RAM address width.
- DATA_WIDTH, default 16, word width.
- DEPTH, default 16, RAM words; DEPTH SHALL equal 2**ADDR_WIDTH.

REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  push request.
- in_ready  out  1  push accepted when in_valid&in_ready at posedge.
- in_data  in  DATA_WIDTH  push word.
- out_valid  out  1  out_data holds FIFO head.
- out_ready  in  1  pop when out_valid&out_ready at posedge.
- out_data  out  DATA_WIDTH  head word.
- count  out  ADDR_WIDTH+1  total words held (RAM + output register).
- full  out  1  ram_count==DEPTH.
- empty  out  1  count==0.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_data  inout  DATA_WIDTH  RAM bidirectional data bus.

Function
REQ-004 The block SHALL implement a FIFO of capacity DEPTH+1: DEPTH words in the external single-port synchronous RAM plus one output register.
REQ-005 RAM read timing SHALL be: address driven in cycle N with cs=1, we=0, oe=1; RAM drives ram_data during cycle N+1 while cs=1, we=0, oe=1.
REQ-006 Internal state SHALL be:
- wr_ptr, rd_ptr, each ADDR_WIDTH bits, wrapping from DEPTH-1 to 0.
- ram_count, range 0..DEPTH.
- FSM states IDLE and RD_DATA.

REQ-007 The FSM SHALL perform at most one RAM access per cycle.
REQ-008 need_read SHALL equal (state==IDLE && out_valid==0 && ram_count!=0), using registered out_valid.
REQ-009 When need_read is true, the block SHALL drive ram_cs=1, ram_we=0, ram_oe=1, ram_addr=rd_ptr, in_ready=0, and move to RD_DATA.
REQ-010 In RD_DATA, the block SHALL:
- hold ram_cs=1, ram_we=0, ram_oe=1, ram_addr=rd_ptr, in_ready=0;
- at posedge, load out_data<=ram_data, set out_valid<=1, rd_ptr+1, ram_count-1;
- move to IDLE.

REQ-011 In IDLE with need_read false, in_ready SHALL equal !full.
REQ-012 In IDLE with need_read false, in_valid&in_ready SHALL be a write cycle:
- ram_cs=1, ram_we=1, ram_oe=0, ram_addr=wr_ptr, ram_data=in_data;
- at posedge, wr_ptr+1, ram_count+1.

REQ-013 Otherwise the block SHALL drive ram_cs=0, ram_we=0, ram_oe=1, and ram_addr=rd_ptr.
REQ-014 The block SHALL drive ram_data only during write cycles and SHALL hold it at high-Z in all other cycles.
REQ-015 A pop SHALL clear out_valid at posedge; a pop and a push in the same IDLE cycle are both SHALL-accepted and leave count unchanged.
REQ-016 A pop in the cycle that need_read is evaluated SHALL NOT trigger a read in that cycle; the read SHALL be issued the next cycle.
REQ-017 count SHALL equal ram_count+out_valid; full and empty SHALL be combinational from registered state.
REQ-018 Latency from a push accepted at the end of cycle N into an empty FIFO to out_valid=1 SHALL be 3 cycles (read issue in N+1, capture in N+2, visible in N+3).
REQ-019 Sustained drain throughput SHALL be one word per 3 cycles.
REQ-020 Data order SHALL be strictly first-in first-out across pointer wrap.
REQ-021 A push while full SHALL be stalled (in_ready=0) with no RAM write and no state change.

Reset
REQ-022 While rst=1, the block SHALL force in_ready=0, ram_cs=0, ram_we=0, ram_oe=1, and ram_data=Z.
REQ-023 At a posedge with rst=1, the block SHALL set wr_ptr=0, rd_ptr=0, ram_count=0, out_valid=0, out_data=0, and state=IDLE.
REQ-024 Reset asserted in RD_DATA SHALL abort the read: no capture, and no pointer or count update.

Verification
REQ-025 Reset: rst=1 for 2 cycles, then rst=0 -> count=0, empty=1, full=0, out_valid=0, in_ready=1, ram_cs=0, ram_data=Z.
REQ-026 Single word: push 0xA5A5 at cycle N with out_ready=0 -> write at addr 0 in N; read at addr 0 in N+1; out_valid=1, out_data=0xA5A5 in N+3; count=1 from N+1 onward.
REQ-027 Fill: push 17 words 0x0001..0x0011 with out_ready=0 -> count=17, full=1, in_ready=0; an 18th push stalls with no RAM write.
REQ-028 Drain: from full, hold out_ready=1 -> words 0x0001..0x0011 appear in order, one per 3 cycles, ending with empty=1 and count=0.
REQ-029 Wrap: 40 random pushes interleaved with pops, occupancy held at 5..12 -> both pointers wrap past 15 to 0; popped sequence equals pushed sequence; simultaneous push+pop leaves count unchanged.
REQ-030 Reset mid-read: assert rst during RD_DATA -> next cycle out_valid=0, count=0, ram_cs=0; out_data not updated from ram_data.
